// File: rtl/rc4_key_schedule.sv
// RC4 key-scheduling (KSA) controller driving the shared S RAM through a registered address/data port.
// Define RC4_INIT_FILL_EN to have the block write S[i]=i itself before permuting.
module rc4_key_schedule #(
   parameter int unsigned KEY_LENGTH = 3
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [8*KEY_LENGTH-1:0]   secret_key,
   output logic [7:0]                s_address,
   output logic [7:0]                s_data,
   output logic                      s_wren,
   input  logic [7:0]                s_q,
   output logic                      busy,
   output logic                      finish
);

   localparam int unsigned KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

   typedef enum logic [3:0] {
      ST_IDLE,
`ifdef RC4_INIT_FILL_EN
      ST_FILL,
`endif
      ST_RD_I,
      ST_WAIT_I,
      ST_RD_J,
      ST_WAIT_J,
      ST_WR_I,
      ST_WR_J,
      ST_NEXT,
      ST_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [7:0]                i_q, i_d;
   logic [7:0]                j_q, j_d;
   logic [KW-1:0]             kidx_q, kidx_d;
   logic [7:0]                si_q, si_d;
   logic [8*KEY_LENGTH-1:0]   key_q, key_d;
   logic [7:0]                addr_q, addr_d;
   logic [7:0]                data_q, data_d;
   logic [7:0]                key_byte;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         kidx_q  <= '0;
         si_q    <= '0;
         key_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         kidx_q  <= kidx_d;
         si_q    <= si_d;
         key_q   <= key_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Key byte 0 sits in the most significant byte of the latched key.
   always_comb begin
      key_byte = '0;
      for (int unsigned k = 0; k < KEY_LENGTH; k++) begin
         if (kidx_q == KW'(k)) begin
            key_byte = key_q[8*(KEY_LENGTH-1-k) +: 8];
         end
      end
   end

   // Address/data registers are loaded with the values for the state being entered.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      kidx_d  = kidx_q;
      si_d    = si_q;
      key_d   = key_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               key_d  = secret_key;
               i_d    = '0;
               j_d    = '0;
               kidx_d = '0;
               addr_d = '0;
               data_d = '0;
`ifdef RC4_INIT_FILL_EN
               state_d = ST_FILL;
`else
               state_d = ST_RD_I;
`endif
            end
         end
`ifdef RC4_INIT_FILL_EN
         ST_FILL: begin
            if (i_q == 8'hFF) begin
               i_d     = '0;
               addr_d  = '0;
               state_d = ST_RD_I;
            end else begin
               i_d    = i_q + 8'd1;
               addr_d = i_q + 8'd1;
               data_d = i_q + 8'd1;
            end
         end
`endif
         ST_RD_I: state_d = ST_WAIT_I;
         ST_WAIT_I: begin
            si_d    = s_q;
            j_d     = j_q + s_q + key_byte;
            addr_d  = j_q + s_q + key_byte;
            state_d = ST_RD_J;
         end
         ST_RD_J: state_d = ST_WAIT_J;
         ST_WAIT_J: begin
            addr_d  = i_q;
            data_d  = s_q;
            state_d = ST_WR_I;
         end
         ST_WR_I: begin
            addr_d  = j_q;
            data_d  = si_q;
            state_d = ST_WR_J;
         end
         ST_WR_J: state_d = ST_NEXT;
         ST_NEXT: begin
            if (i_q == 8'hFF) begin
               addr_d  = '0;
               data_d  = '0;
               state_d = ST_DONE;
            end else begin
               i_d     = i_q + 8'd1;
               addr_d  = i_q + 8'd1;
               kidx_d  = (kidx_q == KW'(KEY_LENGTH - 1)) ? '0 : kidx_q + 1'b1;
               state_d = ST_RD_I;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_wren = (state_q == ST_WR_I) || (state_q == ST_WR_J);
`ifdef RC4_INIT_FILL_EN
      if (state_q == ST_FILL) begin
         s_wren = 1'b1;
      end
`endif
   end

   assign s_address = addr_q;
   assign s_data    = data_q;
   assign busy      = (state_q != ST_IDLE);
   assign finish    = (state_q == ST_DONE);

endmodule

// File: tb/tb_rc4_key_schedule.sv
// Bench for rc4_key_schedule: behavioural S RAM plus a software KSA model that predicts every write and final S.
// Build with RC4_INIT_FILL_EN defined to exercise the self-fill variant.
module tb_rc4_key_schedule;

   localparam int unsigned KL = 3;
`ifdef RC4_INIT_FILL_EN
   localparam int FILLS = 256;
`else
   localparam int FILLS = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [23:0] secret_key;
   logic [7:0]  s_address, s_data, s_q;
   logic        s_wren, busy, finish;

   always #5 clk = ~clk;

   rc4_key_schedule #(.KEY_LENGTH(KL)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .secret_key (secret_key),
      .s_address  (s_address),
      .s_data     (s_data),
      .s_wren     (s_wren),
      .s_q        (s_q),
      .busy       (busy),
      .finish     (finish)
   );

   // Synchronous S RAM: read data appears the cycle after the address.
   logic [7:0] mem [256];
   logic       ram_init;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else if (s_wren) begin
         mem[s_address] <= s_data;
      end
      s_q <= mem[s_address];
   end

   int         errors = 0;
   int         checks = 0;
   logic [7:0] s_model [256];
   logic [7:0] exp_a [$];
   logic [7:0] exp_d [$];
   logic [7:0] cap_a [$];
   logic [7:0] cap_d [$];
   bit         mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Software KSA: predicts the write stream (fill, then WR_I/WR_J pairs) and the final S.
   task automatic build_expect(input logic [23:0] key);
      logic [7:0] s [256];
      logic [7:0] kb [KL];
      logic [7:0] t;
      int j;
      exp_a.delete(); exp_d.delete(); cap_a.delete(); cap_d.delete();
      for (int m = 0; m < KL; m++) kb[m] = key[8*(KL-1-m) +: 8];
`ifdef RC4_INIT_FILL_EN
      for (int k = 0; k < 256; k++) begin
         s[k] = 8'(k);
         exp_a.push_back(8'(k));
         exp_d.push_back(8'(k));
      end
`else
      s = s_model;
`endif
      j = 0;
      for (int i = 0; i < 256; i++) begin
         j = (j + int'(s[i]) + int'(kb[i % KL])) % 256;
         exp_a.push_back(8'(i)); exp_d.push_back(s[j]);
         exp_a.push_back(8'(j)); exp_d.push_back(s[i]);
         t = s[i]; s[i] = s[j]; s[j] = t;
      end
      s_model = s;
   endtask

   task automatic init_identity();
      @(negedge clk); ram_init = 1'b1;
      @(negedge clk); ram_init = 1'b0;
      for (int k = 0; k < 256; k++) s_model[k] = 8'(k);
   endtask

   task automatic monitor();
      logic [7:0] a, d;
      forever begin
         @(negedge clk);
         if (s_wren) begin
            if (!mon_en || exp_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0d data %0d, required no write", s_address, s_data);
            end else begin
               a = exp_a.pop_front();
               d = exp_d.pop_front();
               check("wr_addr", s_address, a);
               check("wr_data", s_data, d);
            end
            cap_a.push_back(s_address);
            cap_d.push_back(s_data);
         end
      end
   endtask

   // nruns>1 keeps start high so each run restarts straight after DONE.
   task automatic do_run(input logic [23:0] key, input int pulse_at, input int abort_at, input int nruns);
      int n, nm, first_bad;
      bit done;
      secret_key = key;
      for (int r = 0; r < nruns; r++) begin
         build_expect(key);
         mon_en = 1'b1;
         if (r == 0) begin
            @(negedge clk);
            start = 1'b1;
         end
         @(posedge clk);
         #1;
         if (r == nruns - 1) begin
            start = 1'b0;
            secret_key = ~key;
         end
         n = 0;
         done = 1'b0;
         while (!done && n < 2100 + FILLS) begin
            @(negedge clk);
            n++;
            if (pulse_at > 0 && n == pulse_at) start = 1'b1;
            else if (pulse_at > 0 && n == pulse_at + 1) start = 1'b0;
            if (n == abort_at) begin
               reset_n = 1'b0;
               #1;
               check("abort_wren", s_wren, 0);
               check("abort_busy", busy, 0);
               check("abort_finish", finish, 0);
               check("abort_addr", s_address, 0);
               mon_en = 1'b0;
               start = 1'b0;
               @(negedge clk);
               reset_n = 1'b1;
`ifndef RC4_INIT_FILL_EN
               init_identity();
`endif
               return;
            end
            if (finish) done = 1'b1;
            else check("busy_during_run", busy, 1);
         end
         // Cycles counted with the start-sampling IDLE cycle as cycle 1.
         check("finish_cycle", n + 1, 1794 + FILLS);
         check("writes_pending", exp_a.size(), 0);
         @(negedge clk);
         check("finish_one_cycle", finish, 0);
         check("idle_after_done", busy, 0);
         nm = 0;
         first_bad = -1;
         for (int k = 0; k < 256; k++) begin
            if (mem[k] !== s_model[k]) begin
               nm++;
               if (first_bad < 0) first_bad = k;
            end
         end
         if (nm != 0) $display("first S difference at %0d: got %0d, required %0d", first_bad, mem[first_bad], s_model[first_bad]);
         check("final_S_mismatches", nm, 0);
      end
      mon_en = 1'b0;
   endtask

   initial begin
      fork
         monitor();
      join_none
      reset_n = 1'b0;
      start = 1'b0;
      secret_key = '0;
      ram_init = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_addr", s_address, 0);
      check("rst_data", s_data, 0);
      check("rst_wren", s_wren, 0);
      check("rst_busy", busy, 0);
      check("rst_finish", finish, 0);
      init_identity();
      reset_n = 1'b1;
      @(negedge clk);

      do_run(24'h010203, 0, 0, 1);
      check("cap_count_010203", cap_a.size(), FILLS + 512);
`ifdef RC4_INIT_FILL_EN
      check("fill_first_addr", cap_a[0], 0);
      check("fill_first_data", cap_d[0], 0);
      check("fill_last_addr", cap_a[255], 255);
      check("fill_last_data", cap_d[255], 255);
`endif
      check("k010203_wri0_addr", cap_a[FILLS + 0], 0);
      check("k010203_wri0_data", cap_d[FILLS + 0], 1);
      check("k010203_wrj0_addr", cap_a[FILLS + 1], 1);
      check("k010203_wrj0_data", cap_d[FILLS + 1], 0);
      check("k010203_wri1_addr", cap_a[FILLS + 2], 1);
      check("k010203_wri1_data", cap_d[FILLS + 2], 3);
      check("k010203_wrj1_addr", cap_a[FILLS + 3], 3);
      check("k010203_wrj1_data", cap_d[FILLS + 3], 0);

`ifndef RC4_INIT_FILL_EN
      init_identity();
`endif
      do_run(24'h000000, 0, 0, 1);
      check("cap_count_000000", cap_a.size(), FILLS + 512);
      check("k000000_wri0_addr", cap_a[FILLS + 0], 0);
      check("k000000_wri0_data", cap_d[FILLS + 0], 0);
      check("k000000_wrj0_addr", cap_a[FILLS + 1], 0);
      check("k000000_wrj0_data", cap_d[FILLS + 1], 0);
      check("k000000_wri1_addr", cap_a[FILLS + 2], 1);
      check("k000000_wri1_data", cap_d[FILLS + 2], 1);

`ifndef RC4_INIT_FILL_EN
      init_identity();
`endif
      do_run(24'h00033C, 0, 0, 1);

      // Abort at WR_I of i=100, then restart from scratch.
      do_run(24'h00033C, 0, FILLS + 705, 1);
      do_run(24'h00033C, 0, 0, 1);

      // Stray start at i=50 must not disturb the run.
      do_run(24'h00033C, FILLS + 351, 0, 1);

      do_run(24'h010203, 0, 0, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
